// File: rtl/cache_pkg.sv
// Shared cache parameters and helpers.
//   TAG_W_DEF    default tag width (12b address minus 4b byte offset)
//   ENTRIES_DEF  default number of cache blocks
//   clog2()      index width helper
//   fill_kind_e  how a fill request is resolved
package cache_pkg;

  localparam int TAG_W_DEF   = 8;
  localparam int ENTRIES_DEF = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {
    FILL_NONE = 2'd0,  // no fill, or dropped by inval_all
    FILL_DUP  = 2'd1,  // tag already resident, no write
    FILL_FREE = 2'd2,  // write lowest invalid entry
    FILL_REPL = 2'd3   // evict entry at rr_ptr
  } fill_kind_e;

endpackage

// File: rtl/tag_match_p.sv
// Single CAM equality cell, purely combinational.
//   vld   entry valid bit
//   tag   stored tag
//   key   tag being searched
//   match vld & (tag == key)
module tag_match_p #(
  parameter int TAG_W = 8
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] key,
  output logic             match
);

  assign match = vld && (tag == key);

endmodule

// File: rtl/tag_cam_lookup.sv
// Fully associative tag store with registered lookup and fill results.
//   clk, rst_n                 clock, async active-low reset
//   lookup_valid, lookup_tag   lookup request
//   fill_valid, fill_tag       install request
//   inval_all                  clear all valid bits (wins over fill)
//   hit_valid, hit, hit_idx    lookup result, one cycle later
//   fill_done, fill_idx        fill result, one cycle later
//   full                       all entries valid after the update
module tag_cam_lookup
  import cache_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IDX_W   = clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             fill_valid,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inval_all,
  output logic             hit_valid,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             fill_done,
  output logic [IDX_W-1:0] fill_idx,
  output logic             full
);

  logic [ENTRIES-1:0][TAG_W-1:0] tags;
  logic [ENTRIES-1:0]            valid, valid_nxt;
  logic [ENTRIES-1:0]            lk_match, fl_match;
  logic [IDX_W-1:0]              rr_ptr;

  // Two match banks: one for lookups, one to detect an already-resident fill tag.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cell
    tag_match_p #(.TAG_W(TAG_W)) u_lk (
      .vld(valid[g]), .tag(tags[g]), .key(lookup_tag), .match(lk_match[g]));
    tag_match_p #(.TAG_W(TAG_W)) u_fl (
      .vld(valid[g]), .tag(tags[g]), .key(fill_tag),   .match(fl_match[g]));
  end

  // Priority encoders; scanning high-to-low leaves the lowest index.
  logic [IDX_W-1:0] lk_idx, fl_idx, free_idx;
  always_comb begin
    lk_idx   = '0;
    fl_idx   = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) lk_idx   = IDX_W'(i);
      if (fl_match[i]) fl_idx   = IDX_W'(i);
      if (!valid[i])   free_idx = IDX_W'(i);
    end
  end

  fill_kind_e       kind;
  logic [IDX_W-1:0] wr_idx, fidx_nxt;
  logic             lk_hit;

  assign lk_hit = lookup_valid && (|lk_match);

  always_comb begin
    kind      = FILL_NONE;
    wr_idx    = rr_ptr;
    fidx_nxt  = fill_idx;
    valid_nxt = valid;
    if (inval_all) begin
      valid_nxt = '0;
      if (fill_valid) fidx_nxt = '0;
    end else if (fill_valid) begin
      if (|fl_match) begin
        kind     = FILL_DUP;
        fidx_nxt = fl_idx;
      end else begin
        kind   = (&valid) ? FILL_REPL : FILL_FREE;
        wr_idx = (&valid) ? rr_ptr : free_idx;
        valid_nxt[wr_idx] = 1'b1;
        fidx_nxt = wr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      rr_ptr    <= '0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      fill_done <= 1'b0;
      fill_idx  <= '0;
      full      <= 1'b0;
    end else begin
      valid     <= valid_nxt;
      full      <= &valid_nxt;
      hit_valid <= lookup_valid;
      hit       <= lk_hit;
      hit_idx   <= lk_hit ? lk_idx : '0;
      fill_done <= fill_valid;
      fill_idx  <= fidx_nxt;
      // Power-of-two ENTRIES, so the increment wraps on its own.
      if (inval_all)              rr_ptr <= '0;
      else if (kind == FILL_REPL) rr_ptr <= rr_ptr + IDX_W'(1);
    end
  end

  // Tag contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (kind == FILL_FREE || kind == FILL_REPL) tags[wr_idx] <= fill_tag;
  end

endmodule
